// File: rtl/multi_clk_divider.sv
// -----------------------------------------------------------------------------
// multi_clk_divider
//   N independent clock-divider channels running from the 100 MHz system clock.
//   Each channel counts up to its active divide value, raises a one-cycle tick
//   at terminal count and drives slowClk either as a 50% square wave (mode 0)
//   or as a pulse that mirrors tick (mode 1). New divide values are written
//   into a per-channel shadow register and only copied into the active value
//   at a period boundary (terminal count, sync or disable). This keeps every
//   output period whole.
//
// Ports
//   clk100Mhz  in   1       system clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   enable     in   NUM_CH  per-channel run enable (0 = held idle, outputs low)
//   mode       in   NUM_CH  per-channel output mode: 0 = square, 1 = pulse
//   sync       in   1       restart every channel in phase
//   load       in   1       write load_val into the shadow of channel load_ch
//   load_ch    in   CH_W    target channel; values >= NUM_CH are ignored
//   load_val   in   CNT_W   new divide value (0 stalls the channel once applied)
//   pending    out  NUM_CH  shadow written but not yet active
//   tick       out  NUM_CH  one-cycle pulse per terminal count
//   slowClk    out  NUM_CH  divided clock output
// -----------------------------------------------------------------------------
module multi_clk_divider #(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned CNT_W       = 28,
  parameter  int unsigned DEFAULT_DIV = 1,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk100Mhz,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] mode,
  input  logic              sync,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_val,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] slowClk
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic             pend_q;
    logic             tick_q;
    logic             slow_q;
    logic             load_hit;
    logic             idle;
    logic             terminal;
    logic             apply;

    // Only channels that exist can match, so out-of-range load_ch is dropped.
    assign load_hit = load && (load_ch == CH_W'(c));
    assign idle     = sync || !enable[c];
    // A zero divide value never reaches terminal; the channel simply stalls.
    assign terminal = (active != '0) && (counter == active - CNT_W'(1));
    // Shadow is copied at any period boundary; a load on that same edge lands
    // in the shadow afterwards and waits for the following boundary.
    assign apply    = pend_q && (idle || terminal);

    always_ff @(posedge clk100Mhz or negedge rst_n) begin
      if (!rst_n) begin
        counter <= '0;
        active  <= CNT_W'(DEFAULT_DIV);
        shadow  <= CNT_W'(DEFAULT_DIV);
        pend_q  <= 1'b0;
        tick_q  <= 1'b0;
        slow_q  <= 1'b0;
      end else begin
        if (idle || active == '0) begin
          counter <= '0;
          tick_q  <= 1'b0;
          slow_q  <= 1'b0;
        end else if (terminal) begin
          counter <= '0;
          tick_q  <= 1'b1;
          slow_q  <= mode[c] ? 1'b1 : ~slow_q;
        end else begin
          counter <= counter + CNT_W'(1);
          tick_q  <= 1'b0;
          if (mode[c]) begin
            slow_q <= 1'b0;
          end
        end

        if (apply) begin
          active <= shadow;
        end

        if (load_hit) begin
          shadow <= load_val;
          pend_q <= 1'b1;
        end else if (apply) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign pending[c] = pend_q;
    assign tick[c]    = tick_q;
    assign slowClk[c] = slow_q;
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// -----------------------------------------------------------------------------
// tb_multi_clk_divider
//   Drives directed scenarios followed by random traffic into a 5-channel,
//   8-bit divider. A behavioural model tracks, per channel, how many cycles
//   have elapsed in the current period and which divide value governs it; a
//   compare process checks every output on every falling clock edge. Directed
//   scenarios also check hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_multi_clk_divider;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 3;

  logic              clk100Mhz;
  logic              rst_n;
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] mode;
  logic              sync;
  logic              load;
  logic [CH_W-1:0]   load_ch;
  logic [CNT_W-1:0]  load_val;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] slowClk;

  int n_checks = 0;
  int n_errors = 0;

  multi_clk_divider #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(1)
  ) dut (
    .clk100Mhz(clk100Mhz),
    .rst_n(rst_n),
    .enable(enable),
    .mode(mode),
    .sync(sync),
    .load(load),
    .load_ch(load_ch),
    .load_val(load_val),
    .pending(pending),
    .tick(tick),
    .slowClk(slowClk)
  );

  initial begin
    clk100Mhz = 1'b0;
    forever #5 clk100Mhz = ~clk100Mhz;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_elapsed [NUM_CH];   // cycles completed in the current period
  int m_div     [NUM_CH];   // divide value governing the current period
  int m_next    [NUM_CH];   // value waiting to govern a later period
  bit m_pend    [NUM_CH];
  bit m_tick    [NUM_CH];
  bit m_slow    [NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_elapsed[c] = 0;
      m_div[c]     = 1;
      m_next[c]    = 1;
      m_pend[c]    = 0;
      m_tick[c]    = 0;
      m_slow[c]    = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit boundary;
      boundary = 0;
      if (sync || !enable[c]) begin
        m_elapsed[c] = 0;
        m_tick[c]    = 0;
        m_slow[c]    = 0;
        boundary     = 1;
      end else if (m_div[c] == 0) begin
        m_tick[c] = 0;
        m_slow[c] = 0;
      end else if (m_elapsed[c] + 1 == m_div[c]) begin
        // period complete
        m_elapsed[c] = 0;
        m_tick[c]    = 1;
        m_slow[c]    = mode[c] ? 1'b1 : !m_slow[c];
        boundary     = 1;
      end else begin
        m_elapsed[c] = m_elapsed[c] + 1;
        m_tick[c]    = 0;
        if (mode[c]) m_slow[c] = 0;
      end
      if (boundary && m_pend[c]) begin
        m_div[c]  = m_next[c];
        m_pend[c] = 0;
      end
      if (load && int'(load_ch) == c) begin
        m_next[c] = int'(load_val);
        m_pend[c] = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk100Mhz or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  always @(negedge clk100Mhz) begin
    logic [NUM_CH-1:0] e_tick, e_slow, e_pend;
    for (int c = 0; c < NUM_CH; c++) begin
      e_tick[c] = m_tick[c];
      e_slow[c] = m_slow[c];
      e_pend[c] = m_pend[c];
    end
    chk("model_tick", tick, e_tick);
    chk("model_slowClk", slowClk, e_slow);
    chk("model_pending", pending, e_pend);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk100Mhz);
    #1;
  endtask

  task automatic do_load(input int ch, input int val);
    load     = 1'b1;
    load_ch  = CH_W'(ch);
    load_val = CNT_W'(val);
    step();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = '0; mode = '0; sync = 1'b0;
    load = 1'b0; load_ch = '0; load_val = '0;
    repeat (3) step();
    chk("reset_tick", tick, 0);
    chk("reset_slowClk", slowClk, 0);
    chk("reset_pending", pending, 0);
    rst_n = 1'b1;

    // default divide of 1: tick every cycle, slowClk = clk/2
    enable = 5'b00001;
    step();
    chk("div1_tick_e1", tick[0], 1);
    chk("div1_slow_e1", slowClk[0], 1);
    step();
    chk("div1_tick_e2", tick[0], 1);
    chk("div1_slow_e2", slowClk[0], 0);

    // asynchronous reset mid-run clears outputs without a clock edge
    do_load(2, 7);
    chk("pend_before_reset", pending[2], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tick", tick, 0);
    chk("async_reset_slowClk", slowClk, 0);
    chk("async_reset_pending", pending, 0);
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("post_reset_tick", tick[0], 1);
    end

    // divide by 3, square mode
    enable = '0;
    do_load(0, 3);
    step();
    enable = 5'b00001;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("div3_tick", tick[0], (k % 3 == 0));
      chk("div3_slow", slowClk[0], (k / 3) % 2);
    end

    // divide by 5, pulse mode
    do_load(1, 5);
    step();
    mode   = 5'b00010;
    enable = 5'b00011;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("pulse5_tick", tick[1], (k % 5 == 0));
      chk("pulse5_slow", slowClk[1], (k % 5 == 0));
    end

    // seamless reload: running at 4, load 2 mid-period
    enable[0] = 1'b0;
    do_load(0, 4);
    step();
    enable[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        load = 1'b1; load_ch = 3'd0; load_val = 8'd2;
      end
      step();
      load = 1'b0;
      chk("reload_tick", tick[0], (k == 4 || k == 6 || k == 8));
      chk("reload_pending", pending[0], (k == 3));
    end

    // sync: four channels at 3/4/5/6 restart in phase
    enable = '0; mode = '0;
    for (int c = 0; c < 4; c++) do_load(c, c + 3);
    step();
    enable = 5'b01111;
    repeat (5) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_edge_tick", tick[3:0], 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      for (int c = 0; c < 4; c++) chk("sync_phase_tick", tick[c], (k % (c + 3) == 0));
    end

    // disable forces outputs low on the next edge
    sync = 1'b1;
    step();
    sync = 1'b0;
    repeat (5) step();
    chk("pre_disable_tick2", tick[2], 1);
    chk("pre_disable_slow2", slowClk[2], 1);
    enable[2] = 1'b0;
    step();
    chk("disable_tick2", tick[2], 0);
    chk("disable_slow2", slowClk[2], 0);

    // load on the same edge as a terminal count applies one period later
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) begin
        load = 1'b1; load_ch = 3'd1; load_val = 8'd2;
      end
      step();
      load = 1'b0;
      chk("coincident_tick", tick[1], (k == 4 || k == 8 || k == 10 || k == 12));
      chk("coincident_pending", pending[1], (k >= 4 && k <= 7));
    end

    // out-of-range channel selects are ignored
    do_load(5, 9);
    do_load(7, 9);
    chk("oor_pending", pending, 0);

    // divide value of 0 stalls the channel low once applied
    do_load(3, 0);
    chk("zero_pending", pending[3], 1);
    repeat (8) step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_tick", tick[3], 0);
      chk("stall_slow", slowClk[3], 0);
      chk("stall_pending", pending[3], 0);
    end

    // random traffic, checked by the model every cycle
    enable = 5'b11111;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) enable = NUM_CH'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) mode   = NUM_CH'($urandom_range(0, 31));
      sync     = ($urandom_range(0, 40) == 0);
      load     = ($urandom_range(0, 5) == 0);
      load_ch  = CH_W'($urandom_range(0, 7));
      load_val = CNT_W'($urandom_range(0, 9));
      if (i == 300) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step();
    end
    sync = 1'b0; load = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
